mem_port_arbiter: RTL

Single-port memory arbiter and sequencer for the pipelined RV64I/Zba core. It shares one memory port between the instruction-fetch stage (read-only, 32-bit instructions) and the memory stage (ld/sd/lw/sw loads and stores, 64-bit). It keeps at most one transaction outstanding, gives data accesses priority with a bounded-starvation guarantee for fetch, and routes each response back to the requester that issued it. Pipeline stall logic is derived from its grant and valid outputs.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// data stage. Keeps one transaction in flight. Data has priority; fetch wins
// once after STARVE_LIMIT consecutive lost arbitrations. Each response is
// routed combinationally to whichever requester owns the transaction.
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   input  logic [7:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [63:0]       d_rdata,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_be,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              owner_q, owner_d;   // 1 = data stage owns the transaction
   logic              hi_q, hi_d;         // fetch wanted the upper word
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        be_q, be_d;

   logic resp;        // response accepted this cycle
   logic grant_pt;    // a new request may be accepted this cycle
   logic fetch_wins;

   // Fetch address bits [1:0] are always zero for aligned instructions.
   logic unused_addr_bits;
   assign unused_addr_bits = ^if_addr[1:0];

   // Arbitration: data wins unless fetch has been starved long enough.
   // Reset gates everything so nothing is accepted while rst_n is low.
   always_comb begin
      resp       = rst_n && (state_q == WAIT) && mem_rvalid;
      grant_pt   = rst_n && ((state_q == IDLE) || resp);
      fetch_wins = if_req && (!d_req || (starve_q >= LIMIT));
      if_gnt     = grant_pt && fetch_wins;
      d_gnt      = grant_pt && d_req && !fetch_wins;
   end

   // Next state, request capture at the grant point, starvation counting.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      owner_d  = owner_q;
      hi_d     = hi_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;

      case (state_q)
         IDLE:    state_d = IDLE;
         ISSUE:   if (mem_gnt) state_d = WAIT;
         WAIT:    if (mem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (if_gnt) begin
         state_d  = ISSUE;
         owner_d  = 1'b0;
         hi_d     = if_addr[2];
         we_d     = 1'b0;
         addr_d   = {if_addr[ADDR_W-1:3], 3'b000};
         wdata_d  = '0;
         be_d     = 8'hFF;
         starve_d = '0;
      end else if (d_gnt) begin
         state_d  = ISSUE;
         owner_d  = 1'b1;
         hi_d     = 1'b0;
         we_d     = d_we;
         addr_d   = d_addr;
         wdata_d  = d_wdata;
         be_d     = d_be;
         if (if_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
      end
   end

   // State and captured-request registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         owner_q  <= 1'b0;
         hi_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         owner_q  <= owner_d;
         hi_q     <= hi_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
      end
   end

   assign mem_req   = (state_q == ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign busy      = (state_q != IDLE);

   // Response routing has no register stage; non-owner sees nothing.
   assign if_rvalid = resp && !owner_q;
   assign d_rvalid  = resp && owner_q;
   assign if_rdata  = if_rvalid ? (hi_q ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'h0;
   assign d_rdata   = d_rvalid ? mem_rdata : 64'h0;

endmodule
